// File: rtl/alu_issue_if.sv
// Handshake and issue-field bundle for alu_issue.
// The master modport belongs to the op source, which also observes the issued fields.
interface alu_issue_if;
  logic        in_valid;
  logic [23:0] in_op;
  logic        in_ready;
  logic        iss_valid;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [3:0]  func;
  logic [7:0]  addr;
  logic        err_illegal;
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;

  modport master (
    output in_valid, in_op,
    input  in_ready, iss_valid, rs1, rs2, rd, func, addr, err_illegal, issue_cnt, stall_cnt
  );

  modport slave (
    input  in_valid, in_op,
    output in_ready, iss_valid, rs1, rs2, rd, func, addr, err_illegal, issue_cnt, stall_cnt
  );
endinterface

// File: rtl/alu_issue.sv
// Issue stage: op FIFO, RAW scoreboard interlock, and illegal-func drop in front of the
// register/ALU/memory pipeline.
module alu_issue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WB_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SbN  = WB_LAT - 1;

  logic [23:0]     mem_q [DEPTH];
  logic [23:0]     mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [SbN-1:0]  sb_v_q, sb_v_d;
  logic [3:0]      sb_rd_q [SbN];
  logic [3:0]      sb_rd_d [SbN];

  logic        iss_valid_q, iss_valid_d;
  logic        err_illegal_q, err_illegal_d;
  logic [3:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, func_q, func_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [23:0] head;
  logic [3:0]  h_func, h_rd, h_rs1, h_rs2;
  logic [7:0]  h_addr;
  logic        in_ready;
  logic        empty, illegal, sb_match, hazard, issue, pop, push;

  assign head = mem_q[rd_ptr_q];
  assign {h_func, h_rd, h_rs1, h_rs2, h_addr} = head;

  // in_ready looks only at the registered count, so a full FIFO stays closed during a pop.
  assign in_ready = (count_q < CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign illegal  = !empty && (h_func >= 4'd12);
  assign push     = bus.in_valid && in_ready;

  always_comb begin
    sb_match = 1'b0;
    for (int i = 0; i < int'(SbN); i++) begin
      if (sb_v_q[i] && ((sb_rd_q[i] == h_rs1) || (sb_rd_q[i] == h_rs2))) begin
        sb_match = 1'b1;
      end
    end
  end

  assign hazard = !empty && !illegal && sb_match;
  assign issue  = !empty && !illegal && !sb_match;
  assign pop    = illegal || issue;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.in_op;
    end
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end

    sb_v_d[0]  = issue;
    sb_rd_d[0] = h_rd;
    for (int i = 1; i < int'(SbN); i++) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end

    iss_valid_d   = issue;
    err_illegal_d = illegal;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    func_d        = func_q;
    addr_d        = addr_q;
    issue_cnt_d   = issue_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (issue) begin
      rs1_d       = h_rs1;
      rs2_d       = h_rs2;
      rd_d        = h_rd;
      func_d      = h_func;
      addr_d      = h_addr;
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if (hazard) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      for (int i = 0; i < int'(SbN); i++) begin
        sb_rd_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      sb_v_q        <= '0;
      iss_valid_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      func_q        <= '0;
      addr_q        <= '0;
      issue_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      mem_q         <= mem_d;
      sb_rd_q       <= sb_rd_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      sb_v_q        <= sb_v_d;
      iss_valid_q   <= iss_valid_d;
      err_illegal_q <= err_illegal_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      func_q        <= func_d;
      addr_q        <= addr_d;
      issue_cnt_q   <= issue_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.iss_valid   = iss_valid_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rd          = rd_q;
  assign bus.func        = func_q;
  assign bus.addr        = addr_q;
  assign bus.issue_cnt   = issue_cnt_q;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule
